// File: rtl/dmem_rr_arbiter.sv
// N-master arbiter sharing one single-port synchronous data RAM.
// Round-robin or fixed-priority grant, read responses steered back to the issuing master.
module dmem_rr_arbiter #(
    parameter int NUM_M    = 2,
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int ARB_MODE = 0
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NUM_M-1:0]           i_m_req,
    input  logic [NUM_M-1:0]           i_m_we,
    input  logic [NUM_M*ADDR_W-1:0]    i_m_addr,
    input  logic [NUM_M*DATA_W-1:0]    i_m_wdata,
    input  logic [NUM_M*DATA_W/8-1:0]  i_m_wstrb,
    output logic [NUM_M-1:0]           o_m_gnt,
    output logic [NUM_M-1:0]           o_m_rvalid,
    output logic [DATA_W-1:0]          o_m_rdata,
    output logic                       o_ram_en,
    output logic [DATA_W/8-1:0]        o_ram_we,
    output logic [ADDR_W-1:0]          o_ram_addr,
    output logic [DATA_W-1:0]          o_ram_wdata,
    input  logic [DATA_W-1:0]          i_ram_rdata,
    output logic [15:0]                o_busy_cnt
);

    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    logic [PTR_W-1:0]  r_rrPtr;
    logic              r_respVld;
    logic [PTR_W-1:0]  r_respId;
    logic [DATA_W-1:0] r_rdataHold;
    logic [15:0]       r_busyCnt;

    logic              w_found;
    logic [PTR_W-1:0]  w_gntIdx;
    logic              w_selRead;
    logic              w_contend;
    logic              w_seen;

    // Two passes: first the masters at or above the pointer, then wrap to the lowest index.
    // In fixed mode the first pass accepts everyone, so the lowest requester wins.
    always_comb begin
        w_found  = 1'b0;
        w_gntIdx = '0;
        if (!i_rst) begin
            for (int i = 0; i < NUM_M; i++) begin
                if (!w_found && i_m_req[i] && (ARB_MODE == 1 || PTR_W'(i) >= r_rrPtr)) begin
                    w_found  = 1'b1;
                    w_gntIdx = PTR_W'(i);
                end
            end
            for (int i = 0; i < NUM_M; i++) begin
                if (!w_found && i_m_req[i]) begin
                    w_found  = 1'b1;
                    w_gntIdx = PTR_W'(i);
                end
            end
        end
    end

    always_comb begin
        o_m_gnt     = '0;
        o_ram_en    = w_found;
        o_ram_we    = '0;
        o_ram_addr  = '0;
        o_ram_wdata = '0;
        w_selRead   = 1'b0;
        for (int i = 0; i < NUM_M; i++) begin
            o_m_gnt[i] = w_found && (w_gntIdx == PTR_W'(i));
            if (o_m_gnt[i]) begin
                o_ram_addr  = i_m_addr[i*ADDR_W +: ADDR_W];
                o_ram_wdata = i_m_wdata[i*DATA_W +: DATA_W];
                o_ram_we    = i_m_we[i] ? i_m_wstrb[i*STRB_W +: STRB_W] : '0;
                w_selRead   = !i_m_we[i];
            end
        end
    end

    always_comb begin
        w_contend = 1'b0;
        w_seen    = 1'b0;
        for (int i = 0; i < NUM_M; i++) begin
            if (i_m_req[i]) begin
                if (w_seen) begin
                    w_contend = 1'b1;
                end
                w_seen = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rrPtr <= '0;
        end else if (w_found && ARB_MODE == 0) begin
            r_rrPtr <= (w_gntIdx == PTR_W'(NUM_M - 1)) ? '0 : w_gntIdx + 1'b1;
        end
    end

    // Response tag follows the read grant by one cycle, when the RAM presents its data.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_respVld   <= 1'b0;
            r_respId    <= '0;
            r_rdataHold <= '0;
        end else begin
            r_respVld <= w_selRead;
            if (w_selRead) begin
                r_respId <= w_gntIdx;
            end
            if (r_respVld) begin
                r_rdataHold <= i_ram_rdata;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busyCnt <= '0;
        end else if (w_contend && r_busyCnt != 16'hFFFF) begin
            r_busyCnt <= r_busyCnt + 16'd1;
        end
    end

    always_comb begin
        o_m_rvalid = '0;
        for (int i = 0; i < NUM_M; i++) begin
            o_m_rvalid[i] = r_respVld && (r_respId == PTR_W'(i));
        end
    end

    assign o_m_rdata  = r_respVld ? i_ram_rdata : r_rdataHold;
    assign o_busy_cnt = r_busyCnt;

endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// Directed bench for dmem_rr_arbiter: three instances (2-master RR, 2-master fixed, 4-master RR)
// share one stimulus set, each with its own behavioural RAM; read responses go through a scoreboard queue.
module tb_dmem_rr_arbiter;

    typedef struct {
        int          id;
        logic [31:0] data;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  we;
    logic [9:0]  addr  [4];
    logic [31:0] wdata [4];
    logic [3:0]  wstrb [4];
    int          sel;

    int          nChecks = 0;
    int          nFail   = 0;
    resp_t       expQ[$];

    logic [1:0]  gntA, rvA, gntB, rvB;
    logic [3:0]  gntC, rvC;
    logic [31:0] rdataA, rdataB, rdataC;
    logic        enA, enB, enC;
    logic [3:0]  weA, weB, weC;
    logic [9:0]  addrA, addrB, addrC;
    logic [31:0] wdA, wdB, wdC;
    logic [31:0] ramRdA, ramRdB, ramRdC;
    logic [15:0] busyA, busyB, busyC;

    logic [31:0] memA [0:1023];
    logic [31:0] memB [0:1023];
    logic [31:0] memC [0:1023];

    logic [3:0]  obsGnt, obsRvalid;
    logic [31:0] obsRdata;
    logic        obsRamEn;
    logic [3:0]  obsRamWe;
    logic [15:0] obsBusy;

    always #5 clk = ~clk;

    dmem_rr_arbiter #(.NUM_M(2), .ADDR_W(10), .DATA_W(32), .ARB_MODE(0)) dutA (
        .i_clk(clk), .i_rst(rst), .i_m_req(req[1:0]), .i_m_we(we[1:0]),
        .i_m_addr({addr[1], addr[0]}), .i_m_wdata({wdata[1], wdata[0]}),
        .i_m_wstrb({wstrb[1], wstrb[0]}), .o_m_gnt(gntA), .o_m_rvalid(rvA), .o_m_rdata(rdataA),
        .o_ram_en(enA), .o_ram_we(weA), .o_ram_addr(addrA), .o_ram_wdata(wdA),
        .i_ram_rdata(ramRdA), .o_busy_cnt(busyA)
    );

    dmem_rr_arbiter #(.NUM_M(2), .ADDR_W(10), .DATA_W(32), .ARB_MODE(1)) dutB (
        .i_clk(clk), .i_rst(rst), .i_m_req(req[1:0]), .i_m_we(we[1:0]),
        .i_m_addr({addr[1], addr[0]}), .i_m_wdata({wdata[1], wdata[0]}),
        .i_m_wstrb({wstrb[1], wstrb[0]}), .o_m_gnt(gntB), .o_m_rvalid(rvB), .o_m_rdata(rdataB),
        .o_ram_en(enB), .o_ram_we(weB), .o_ram_addr(addrB), .o_ram_wdata(wdB),
        .i_ram_rdata(ramRdB), .o_busy_cnt(busyB)
    );

    dmem_rr_arbiter #(.NUM_M(4), .ADDR_W(10), .DATA_W(32), .ARB_MODE(0)) dutC (
        .i_clk(clk), .i_rst(rst), .i_m_req(req), .i_m_we(we),
        .i_m_addr({addr[3], addr[2], addr[1], addr[0]}),
        .i_m_wdata({wdata[3], wdata[2], wdata[1], wdata[0]}),
        .i_m_wstrb({wstrb[3], wstrb[2], wstrb[1], wstrb[0]}),
        .o_m_gnt(gntC), .o_m_rvalid(rvC), .o_m_rdata(rdataC),
        .o_ram_en(enC), .o_ram_we(weC), .o_ram_addr(addrC), .o_ram_wdata(wdC),
        .i_ram_rdata(ramRdC), .o_busy_cnt(busyC)
    );

    // Behavioural single-port RAMs with byte enables and one-cycle read latency
    always @(posedge clk) begin
        if (enA) begin
            for (int b = 0; b < 4; b++) if (weA[b]) memA[addrA][b*8 +: 8] <= wdA[b*8 +: 8];
            if (weA == 4'd0) ramRdA <= memA[addrA];
        end
    end

    always @(posedge clk) begin
        if (enB) begin
            for (int b = 0; b < 4; b++) if (weB[b]) memB[addrB][b*8 +: 8] <= wdB[b*8 +: 8];
            if (weB == 4'd0) ramRdB <= memB[addrB];
        end
    end

    always @(posedge clk) begin
        if (enC) begin
            for (int b = 0; b < 4; b++) if (weC[b]) memC[addrC][b*8 +: 8] <= wdC[b*8 +: 8];
            if (weC == 4'd0) ramRdC <= memC[addrC];
        end
    end

    // Route the instance under test onto one set of observation signals
    always_comb begin
        obsGnt    = 4'd0;
        obsRvalid = 4'd0;
        obsRdata  = 32'd0;
        obsRamEn  = 1'b0;
        obsRamWe  = 4'd0;
        obsBusy   = 16'd0;
        case (sel)
            0: begin
                obsGnt = {2'b00, gntA}; obsRvalid = {2'b00, rvA}; obsRdata = rdataA;
                obsRamEn = enA; obsRamWe = weA; obsBusy = busyA;
            end
            1: begin
                obsGnt = {2'b00, gntB}; obsRvalid = {2'b00, rvB}; obsRdata = rdataB;
                obsRamEn = enB; obsRamWe = weB; obsBusy = busyB;
            end
            default: begin
                obsGnt = gntC; obsRvalid = rvC; obsRdata = rdataC;
                obsRamEn = enC; obsRamWe = weC; obsBusy = busyC;
            end
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected)
        else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Inputs are already driven; sample mid-cycle, retire any due response, queue a new one if this grant reads
    task automatic applyStimulus(input string tag, input logic [3:0] expGnt, input bit rd,
                                 input logic [31:0] rdExp);
        resp_t e;
        @(negedge clk);
        checkOutput({tag, ".gnt"}, 32'(obsGnt), 32'(expGnt));
        checkOutput({tag, ".ram_en"}, 32'(obsRamEn), 32'(expGnt != 4'd0));
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput({tag, ".rvalid"}, 32'(obsRvalid), 32'(4'b0001 << e.id));
            checkOutput({tag, ".rdata"}, obsRdata, e.data);
        end else begin
            checkOutput({tag, ".rvalid"}, 32'(obsRvalid), 32'd0);
        end
        if (rd) begin
            e.id = 0;
            for (int i = 0; i < 4; i++) if (expGnt[i]) e.id = i;
            e.data = rdExp;
            expQ.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        sel = 0;
        rst = 1'b1;
        req = 4'b0011;
        we  = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            addr[i]  = 10'd0;
            wdata[i] = 32'd0;
            wstrb[i] = 4'hF;
        end

        // Reset with contending requests present
        @(negedge clk);
        checkOutput("rst.gnt", 32'(obsGnt), 32'd0);
        checkOutput("rst.ram_en", 32'(obsRamEn), 32'd0);
        checkOutput("rst.rvalid", 32'(obsRvalid), 32'd0);
        checkOutput("rst.rdata", obsRdata, 32'd0);
        checkOutput("rst.busy", 32'(obsBusy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 4'b0000;

        // Single master write then read back
        req = 4'b0001; we = 4'b0001; addr[0] = 10'h010; wdata[0] = 32'hDEADBEEF; wstrb[0] = 4'hF;
        applyStimulus("t1.wr", 4'b0001, 1'b0, 32'd0);
        we = 4'b0000;
        applyStimulus("t1.rd", 4'b0001, 1'b1, 32'hDEADBEEF);

        // Byte strobes, then an all-zero-strobe write that must not disturb memory
        we = 4'b0001; addr[0] = 10'h020; wdata[0] = 32'h11223344; wstrb[0] = 4'hF;
        applyStimulus("t4.wr1", 4'b0001, 1'b0, 32'd0);
        wdata[0] = 32'hAABBCCDD; wstrb[0] = 4'b0101;
        applyStimulus("t4.wr2", 4'b0001, 1'b0, 32'd0);
        we = 4'b0000;
        applyStimulus("t4.rd", 4'b0001, 1'b1, 32'h11BB33DD);
        we = 4'b0001; wdata[0] = 32'hFFFFFFFF; wstrb[0] = 4'b0000;
        applyStimulus("t4.wr0", 4'b0001, 1'b0, 32'd0);
        checkOutput("t4.hold", obsRdata, 32'h11BB33DD);
        we = 4'b0000; wstrb[0] = 4'hF;
        applyStimulus("t4.rd0", 4'b0001, 1'b1, 32'h11BB33DD);
        req = 4'b0000;
        applyStimulus("t4.idle", 4'b0000, 1'b0, 32'd0);

        // Round-robin: park the pointer on master 0, then six contended cycles
        req = 4'b0010; addr[0] = 10'h010; addr[1] = 10'h020;
        applyStimulus("t2.pre", 4'b0010, 1'b1, 32'h11BB33DD);
        req = 4'b0011;
        for (int c = 0; c < 6; c++) begin
            if (c % 2 == 0) applyStimulus("t2.rr", 4'b0001, 1'b1, 32'hDEADBEEF);
            else            applyStimulus("t2.rr", 4'b0010, 1'b1, 32'h11BB33DD);
        end
        req = 4'b0000;
        checkOutput("t2.busy", 32'(obsBusy), 32'd6);
        applyStimulus("t2.idle", 4'b0000, 1'b0, 32'd0);

        // Fixed priority: master 1 starves until master 0 drops
        sel = 1;
        req = 4'b0011;
        for (int c = 0; c < 3; c++) applyStimulus("t3.fix", 4'b0001, 1'b1, 32'hDEADBEEF);
        req = 4'b0010;
        applyStimulus("t3.m1", 4'b0010, 1'b1, 32'h11BB33DD);
        req = 4'b0000;
        applyStimulus("t3.idle", 4'b0000, 1'b0, 32'd0);

        // Reset right after a read grant, with a write pending during reset
        sel = 0;
        req = 4'b0001;
        applyStimulus("t5.rd", 4'b0001, 1'b0, 32'd0);
        rst = 1'b1;
        we = 4'b0001; wdata[0] = 32'h00000000; wstrb[0] = 4'hF;
        applyStimulus("t5.inrst", 4'b0000, 1'b0, 32'd0);
        checkOutput("t5.ram_we", 32'(obsRamWe), 32'd0);
        checkOutput("t5.busy", 32'(obsBusy), 32'd0);
        rst = 1'b0;
        req = 4'b0011; we = 4'b0000;
        applyStimulus("t5.rel0", 4'b0001, 1'b1, 32'hDEADBEEF);
        applyStimulus("t5.rel1", 4'b0010, 1'b1, 32'h11BB33DD);
        req = 4'b0000;
        applyStimulus("t5.idle", 4'b0000, 1'b0, 32'd0);

        // Four masters, only 1 and 3 active, pointer steered to 2
        sel = 2;
        req = 4'b1000; we = 4'b1000; addr[3] = 10'h030; wdata[3] = 32'h33330003; wstrb[3] = 4'hF;
        applyStimulus("t6.wr3", 4'b1000, 1'b0, 32'd0);
        req = 4'b0010; we = 4'b0000;
        applyStimulus("t6.pre", 4'b0010, 1'b1, 32'h11BB33DD);
        req = 4'b1010;
        applyStimulus("t6.g3a", 4'b1000, 1'b1, 32'h33330003);
        applyStimulus("t6.g1", 4'b0010, 1'b1, 32'h11BB33DD);
        applyStimulus("t6.g3b", 4'b1000, 1'b1, 32'h33330003);
        req = 4'b0000;
        applyStimulus("t6.idle", 4'b0000, 1'b0, 32'd0);
        checkOutput("t6.queue", 32'(expQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
        $finish;
    end

endmodule
